// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - instruction prefetch queue between imem port and IF/ID
// Sequential fetcher with in-flight PC tagging, DEPTH-entry queue and redirect flush.
module instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_code,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW:0]   SUM_MAX = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   code_q      [DEPTH];
  logic [31:0]   pc_q        [DEPTH];
  logic [31:0]   inflight_pc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, if_wr_ptr, if_rd_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW:0]   committed;
  logic          issue, rsp, keep, pop;

  // Requests still owed to the queue: stale (discarded) responses do not reserve a slot.
  assign committed = {1'b0, count} + {1'b0, outstanding} - {1'b0, discard};

  assign mem_req  = rst & ~i_redirect & (committed < SUM_MAX) & (outstanding < CNT_MAX);
  assign mem_addr = fetch_pc;

  assign issue = mem_req & mem_gnt;
  assign rsp   = mem_rvalid & (outstanding != '0);
  assign keep  = rsp & (discard == '0) & ~i_redirect;
  assign pop   = o_valid & ~i_stall & ~i_redirect;

  assign o_valid = (count != '0);
  assign o_code  = o_valid ? code_q[rd_ptr] : 32'h0;
  assign o_pc    = o_valid ? pc_q[rd_ptr] : 32'h0;
  assign o_pc4   = o_valid ? (pc_q[rd_ptr] + 32'd4) : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      if_wr_ptr   <= '0;
      if_rd_ptr   <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (issue) begin
        fetch_pc  <= fetch_pc + 32'd4;
        if_wr_ptr <= if_wr_ptr + PTR_ONE;
      end
      // The in-flight PC FIFO survives redirects so it stays aligned with the memory.
      if (rsp) if_rd_ptr <= if_rd_ptr + PTR_ONE;
      outstanding <= outstanding + (issue ? CNT_ONE : '0) - (rsp ? CNT_ONE : '0);

      if (i_redirect) begin
        fetch_pc <= {i_redirect_pc[31:2], 2'b00};
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        discard  <= outstanding - (rsp ? CNT_ONE : '0);
      end else begin
        if (rsp && discard != '0) discard <= discard - CNT_ONE;
        if (keep) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        count <= count + (keep ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc[if_wr_ptr] <= fetch_pc;
    if (keep) begin
      code_q[wr_ptr] <= mem_rdata;
      pc_q[wr_ptr]   <= inflight_pc[if_rd_ptr];
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - randomized bench for instr_prefetch against an epoch-based queue model
module tb_instr_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_valid;
  logic [31:0] o_code, o_pc, o_pc4;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .o_code(o_code), .o_pc(o_pc), .o_pc4(o_pc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        memq[$];
  logic [31:0] exp_pc[$];
  logic [31:0] mpc;
  int          epoch, cyc;
  int          n_checks, n_errors;

  int p_gnt, p_rv, p_stall, p_redir, p_junk, lat_min, lat_max;
  bit frc_stall, frc_redir;
  logic [31:0] frc_target;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    if (exp_pc.size() > 0) begin
      check("o_valid", {31'h0, o_valid}, 32'h1);
      check("o_pc", o_pc, exp_pc[0]);
      check("o_code", o_code, tag(exp_pc[0]));
      check("o_pc4", o_pc4, exp_pc[0] + 32'd4);
    end else begin
      check("o_valid", {31'h0, o_valid}, 32'h0);
      check("o_code_idle", o_code, 32'h0);
      check("o_pc_idle", o_pc, 32'h0);
      check("o_pc4_idle", o_pc4, 32'h0);
    end
  endtask

  task automatic run_cycle();
    bit st, rd, g, rv, junk, exp_req, do_pop, keep;
    logic [31:0] tgt;
    int live, lat;
    req_t r;
    @(negedge clk);
    check_outputs();
    st   = frc_stall || ($urandom_range(99) < p_stall);
    rd   = frc_redir || ($urandom_range(99) < p_redir);
    tgt  = frc_redir ? frc_target : $urandom;
    g    = $urandom_range(99) < p_gnt;
    rv   = 1'b0;
    junk = 1'b0;
    if (memq.size() > 0) begin
      if (memq[0].due <= cyc && $urandom_range(99) < p_rv) rv = 1'b1;
    end else if ($urandom_range(99) < p_junk) begin
      junk = 1'b1;
    end
    i_stall       = st;
    i_redirect    = rd;
    i_redirect_pc = tgt;
    mem_gnt       = g;
    mem_rvalid    = rv | junk;
    mem_rdata     = rv ? tag(memq[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (memq[i]) if (memq[i].epoch == epoch) live++;
    exp_req = !rd && (exp_pc.size() + live < DEPTH) && (memq.size() < DEPTH);
    check("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
    check("mem_addr", mem_addr, mpc);
    @(posedge clk);
    do_pop = (exp_pc.size() > 0) && !st && !rd;
    keep   = 1'b0;
    if (rv) begin
      r    = memq.pop_front();
      keep = !rd && (r.epoch == epoch);
    end
    if (exp_req && g) begin
      lat = $urandom_range(lat_max, lat_min);
      memq.push_back('{addr: mpc, epoch: epoch, due: cyc + lat});
      mpc = mpc + 32'd4;
    end
    if (rd) begin
      exp_pc.delete();
      epoch++;
      mpc = {tgt[31:2], 2'b00};
    end else begin
      if (do_pop) void'(exp_pc.pop_front());
      if (keep) exp_pc.push_back(r.addr);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    i_stall    = 1'b0;
    i_redirect = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("rst_o_valid", {31'h0, o_valid}, 32'h0);
    check("rst_o_code", o_code, 32'h0);
    check("rst_o_pc", o_pc, 32'h0);
    check("rst_o_pc4", o_pc4, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    memq.delete();
    exp_pc.delete();
    mpc = RESET_PC;
    epoch++;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic knobs(input int g, input int rv, input int lmin, input int lmax,
                       input int st, input int rd, input int jk);
    p_gnt = g; p_rv = rv; lat_min = lmin; lat_max = lmax;
    p_stall = st; p_redir = rd; p_junk = jk;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; epoch = 0; cyc = 0; mpc = RESET_PC;
    frc_stall = 1'b0; frc_redir = 1'b0; frc_target = 32'h0;
    knobs(100, 100, 1, 1, 0, 0, 0);
    apply_reset();

    run(12);

    frc_stall = 1'b1;
    run(6);
    frc_stall = 1'b0;
    run(8);

    knobs(100, 100, 3, 3, 0, 0, 0);
    run(4);
    frc_redir = 1'b1; frc_target = 32'h0000_0103;
    run(1);
    frc_redir = 1'b0;
    run(10);

    knobs(100, 100, 1, 1, 0, 0, 0);
    run(3);
    frc_stall = 1'b1; frc_redir = 1'b1; frc_target = 32'h0000_2000;
    run(1);
    frc_stall = 1'b0; frc_redir = 1'b0;
    run(6);

    frc_redir = 1'b1; frc_target = 32'hFFFF_FFF8;
    run(1);
    frc_redir = 1'b0;
    run(8);

    knobs(100, 100, 2, 2, 0, 0, 0);
    frc_stall = 1'b1;
    run(3);
    frc_stall = 1'b0;
    apply_reset();
    knobs(100, 100, 1, 1, 0, 0, 0);
    run(10);

    knobs(70, 70, 1, 4, 25, 5, 5);
    run(2000);

    knobs(100, 100, 1, 1, 0, 0, 0);
    apply_reset();
    run(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
